// File: rtl/spi_job_scheduler_if.sv
// APB bus between the job scheduler (master) and the SPI register file (slave).
// Latency: none, wires only.
// Backpressure: slave stretches ACCESS phases by holding pready_i low.
interface spi_job_scheduler_if;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [3:0]  paddr_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;

  modport master (
    output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    input  prdata_i, pready_i
  );

  modport slave (
    input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
    output prdata_i, pready_i
  );
endinterface

// File: rtl/spi_job_scheduler.sv
// Round-robin two-port SPI job scheduler; sole APB master on apb_spi_master.
// Latency: 16 cycles request-to-done with zero-wait APB and one poll; +2+POLL_GAP per busy poll.
// Backpressure: APB ACCESS held while pready_i=0; requests wait in IDLE. Macro SPI_SCHED_TIMEOUT_EN bounds polling.
module spi_job_scheduler #(
  parameter int unsigned POLL_GAP = 2,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        pclk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic [7:0]  cmd0_i,
  input  logic [7:0]  cmd1_i,
  input  logic [31:0] addr0_i,
  input  logic [31:0] addr1_i,
  input  logic [31:0] len0_i,
  input  logic [31:0] len1_i,
  input  logic [31:0] wdata0_i,
  input  logic [31:0] wdata1_i,
  output logic        done0_o,
  output logic        done1_o,
  output logic [31:0] rdata0_o,
  output logic [31:0] rdata1_o,
  output logic        err0_o,
  output logic        err1_o,
  output logic        busy_o,
  spi_job_scheduler_if.master apb
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_W_CMD, S_W_ADDR, S_W_LEN, S_W_WDATA, S_W_CTRL,
    S_POLL, S_GAP, S_R_DATA, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;       // 0 = SETUP, 1 = ACCESS
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [31:0] addr_q, addr_d, len_q, len_d, wdata_q, wdata_d;
  logic [3:0]  gap_q, gap_d;
  logic        psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [3:0]  paddr_q, paddr_d;
  logic [31:0] pwdata_q, pwdata_d;
  logic        done0_q, done0_d, done1_q, done1_d, busy_q, busy_d;
  logic [31:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic        tmo_hit;

`ifdef SPI_SCHED_TIMEOUT_EN
  localparam int unsigned POLL_W = $clog2(TIMEOUT + 1);
  logic [POLL_W-1:0] poll_q, poll_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  // The poll that would exceed the budget while still busy ends the job.
  assign tmo_hit = (32'(poll_q) + 32'd1) >= TIMEOUT;
  assign err0_o  = err0_q;
  assign err1_o  = err1_q;
`else
  assign tmo_hit = 1'b0;
  assign err0_o  = 1'b0;
  assign err1_o  = 1'b0;
`endif

  // Next-state, job latching and completion bookkeeping.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    gap_d    = gap_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SPI_SCHED_TIMEOUT_EN
    poll_d   = poll_q;
    err0_d   = err0_q;
    err1_d   = err1_q;
`endif
    unique case (state_q)
      S_IDLE: if (req0_i || req1_i) state_d = S_ARB;
      S_ARB: begin
        if (req0_i || req1_i) begin
          // Tie goes to the port that did not finish last.
          gnt_d   = (req0_i && req1_i) ? ~last_q : req1_i;
          cmd_d   = gnt_d ? cmd1_i   : cmd0_i;
          addr_d  = gnt_d ? addr1_i  : addr0_i;
          len_d   = gnt_d ? len1_i   : len0_i;
          wdata_d = gnt_d ? wdata1_i : wdata0_i;
          phase_d = 1'b0;
          state_d = S_W_CMD;
`ifdef SPI_SCHED_TIMEOUT_EN
          poll_d  = '0;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_CMD, S_W_ADDR, S_W_LEN, S_W_WDATA, S_W_CTRL, S_POLL, S_R_DATA: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (apb.pready_i) begin
          phase_d = 1'b0;
          unique case (state_q)
            S_W_CMD:   state_d = S_W_ADDR;
            S_W_ADDR:  state_d = S_W_LEN;
            S_W_LEN:   state_d = S_W_WDATA;
            S_W_WDATA: state_d = S_W_CTRL;
            S_W_CTRL:  state_d = S_POLL;
            S_POLL: begin
`ifdef SPI_SCHED_TIMEOUT_EN
              poll_d = poll_q + 1'b1;
`endif
              if (!apb.prdata_i[0]) begin
                state_d = S_R_DATA;
              end else if (tmo_hit) begin
                state_d = S_DONE;
                if (gnt_q) rdata1_d = 32'hDEAD_BEEF;
                else       rdata0_d = 32'hDEAD_BEEF;
`ifdef SPI_SCHED_TIMEOUT_EN
                if (gnt_q) err1_d = 1'b1;
                else       err0_d = 1'b1;
`endif
              end else if (POLL_GAP == 0) begin
                state_d = S_POLL;
              end else begin
                gap_d   = 4'(POLL_GAP - 1);
                state_d = S_GAP;
              end
            end
            S_R_DATA: begin
              if (gnt_q) rdata1_d = apb.prdata_i;
              else       rdata0_d = apb.prdata_i;
`ifdef SPI_SCHED_TIMEOUT_EN
              if (gnt_q) err1_d = 1'b0;
              else       err0_d = 1'b0;
`endif
              state_d = S_DONE;
            end
            default: state_d = state_q;
          endcase
        end
      end
      S_GAP: begin
        if (gap_q == 4'd0) state_d = S_POLL;
        else               gap_d   = gap_q - 4'd1;
      end
      S_DONE: begin
        last_d  = gnt_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered APB/status outputs decoded from the next state so they align with it.
  always_comb begin
    psel_d    = 1'b0;
    pwrite_d  = 1'b0;
    paddr_d   = 4'd0;
    pwdata_d  = 32'd0;
    unique case (state_d)
      S_W_CMD:   begin psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = 4'd0; pwdata_d = {24'd0, cmd_d}; end
      S_W_ADDR:  begin psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = 4'd1; pwdata_d = addr_d;  end
      S_W_LEN:   begin psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = 4'd2; pwdata_d = len_d;   end
      S_W_WDATA: begin psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = 4'd3; pwdata_d = wdata_d; end
      S_W_CTRL:  begin psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = 4'd5; pwdata_d = 32'h1;   end
      S_POLL:    begin psel_d = 1'b1; paddr_d = 4'd5; end
      S_R_DATA:  begin psel_d = 1'b1; paddr_d = 4'd4; end
      default:   psel_d = 1'b0;
    endcase
    penable_d = psel_d && phase_d;
    done0_d   = (state_d == S_DONE) && !gnt_d;
    done1_d   = (state_d == S_DONE) && gnt_d;
    busy_d    = (state_d != S_IDLE);
  end

  // All state; reset abandons any in-flight access and job.
  always_ff @(posedge pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      cmd_q     <= 8'd0;
      addr_q    <= 32'd0;
      len_q     <= 32'd0;
      wdata_q   <= 32'd0;
      gap_q     <= 4'd0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= 4'd0;
      pwdata_q  <= 32'd0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      busy_q    <= 1'b0;
      rdata0_q  <= 32'd0;
      rdata1_q  <= 32'd0;
`ifdef SPI_SCHED_TIMEOUT_EN
      poll_q    <= '0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      wdata_q   <= wdata_d;
      gap_q     <= gap_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      busy_q    <= busy_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
`ifdef SPI_SCHED_TIMEOUT_EN
      poll_q    <= poll_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
`endif
    end
  end

  assign apb.psel_o    = psel_q;
  assign apb.penable_o = penable_q;
  assign apb.pwrite_o  = pwrite_q;
  assign apb.paddr_o   = paddr_q;
  assign apb.pwdata_o  = pwdata_q;
  assign done0_o       = done0_q;
  assign done1_o       = done1_q;
  assign rdata0_o      = rdata0_q;
  assign rdata1_o      = rdata1_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_spi_job_scheduler.sv
// Directed bench for spi_job_scheduler with a behavioural APB SPI-register slave.
// Latency: n/a.
// Backpressure: slave wait states and busy-poll count are set per test.
module tb_spi_job_scheduler;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  cmd0 = '0, cmd1 = '0;
  logic [31:0] addr0 = '0, addr1 = '0, len0 = '0, len1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err0, err1, busy;
  logic [31:0] rdata0, rdata1;

  spi_job_scheduler_if apb ();

  spi_job_scheduler #(.POLL_GAP(2), .TIMEOUT(8)) dut (
    .pclk_i(pclk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .cmd0_i(cmd0), .cmd1_i(cmd1),
    .addr0_i(addr0), .addr1_i(addr1),
    .len0_i(len0), .len1_i(len1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .done0_o(done0), .done1_o(done1),
    .rdata0_o(rdata0), .rdata1_o(rdata1),
    .err0_o(err0), .err1_o(err1),
    .busy_o(busy),
    .apb(apb)
  );

  always #5 pclk = ~pclk;

  // ---------------- slave model ----------------
  typedef struct packed {
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] cyc;
  } acc_t;

  int          waits    = 0;      // wait states per ACCESS
  int          busy_set = 0;      // busy polls before clear
  int          ctrl_base = 0;
  logic [31:0] rd_val   = 32'h0;
  int          ctrl_reads = 0;    // monotonic, monitor-owned
  int          unstable   = 0;    // monotonic, monitor-owned
  int          wcnt = 0, acc_len = 0;
  logic [31:0] cyc = 0;
  logic [3:0]  sv_a;
  logic [31:0] sv_d;
  acc_t        log_q[$];
  int          len_q[$];
  int          order_q[$];

  wire xfer = apb.psel_o && apb.penable_o && apb.pready_i;
  assign apb.pready_i = apb.psel_o && apb.penable_o && (wcnt == waits);
  assign apb.prdata_i = (apb.paddr_o == 4'd5) ? {31'd0, (ctrl_reads - ctrl_base) < busy_set} :
                        (apb.paddr_o == 4'd4) ? rd_val : 32'd0;

  always @(posedge pclk) begin
    cyc <= cyc + 1;
    if (apb.psel_o && apb.penable_o && !apb.pready_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (apb.psel_o && !apb.penable_o) begin
      sv_a <= apb.paddr_o;
      sv_d <= apb.pwdata_o;
    end
    if (apb.psel_o && apb.penable_o && (apb.paddr_o != sv_a || apb.pwdata_o != sv_d))
      unstable <= unstable + 1;
    if (apb.penable_o) begin
      if (apb.pready_i) begin
        len_q.push_back(acc_len + 1);
        acc_len <= 0;
      end else begin
        acc_len <= acc_len + 1;
      end
    end
    if (xfer) begin
      log_q.push_back({apb.pwrite_o, apb.paddr_o, apb.pwdata_o, cyc});
      if (!apb.pwrite_o && apb.paddr_o == 4'd5) ctrl_reads <= ctrl_reads + 1;
    end
  end

  // ---------------- checking ----------------
  int vecs = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    log_q.delete();
    len_q.delete();
  endtask

  // Posts one job and counts edges until its done pulse.
  task automatic run_job(input int port, input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] l, input logic [31:0] w, output int lat);
    if (port == 0) begin cmd0 = c; addr0 = a; len0 = l; wdata0 = w; req0 = 1'b1; end
    else           begin cmd1 = c; addr1 = a; len1 = l; wdata1 = w; req1 = 1'b1; end
    lat = 0;
    do begin
      @(posedge pclk); #1;
      lat++;
    end while (!(port == 0 ? done0 : done1) && lat < 3000);
    if (!(port == 0 ? done0 : done1)) chk("job_wait_expired", 64'd0, 64'd1);
    if (port == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic check_seq(input logic [7:0] c, input logic [31:0] a, input logic [31:0] l,
                           input logic [31:0] w);
    logic [36:0] exp [7];
    exp[0] = {1'b1, 4'd0, 24'd0, c};
    exp[1] = {1'b1, 4'd1, a};
    exp[2] = {1'b1, 4'd2, l};
    exp[3] = {1'b1, 4'd3, w};
    exp[4] = {1'b1, 4'd5, 32'h1};
    exp[5] = {1'b0, 4'd5, 32'h0};
    exp[6] = {1'b0, 4'd4, 32'h0};
    chk("seq_len", 64'(log_q.size()), 64'd7);
    for (int i = 0; i < 7 && i < log_q.size(); i++) begin
      // Read data is not part of the pwdata expectation.
      logic [36:0] got;
      got = {log_q[i].w, log_q[i].a, log_q[i].w ? log_q[i].d : 32'h0};
      chk($sformatf("seq_%0d", i), 64'(got), 64'(exp[i]));
    end
  endtask

  task automatic drive_port(input int port, input int n);
    for (int j = 0; j < n; j++) begin
      int t;
      t = 0;
      if (port == 0) req0 = 1'b1; else req1 = 1'b1;
      do begin
        @(posedge pclk); #1;
        t++;
      end while (!(port == 0 ? done0 : done1) && t < 400);
      if (!(port == 0 ? done0 : done1)) chk("alt_wait_expired", 64'd0, 64'd1);
      order_q.push_back(port);
      if (port == 0) req0 = 1'b0; else req1 = 1'b0;
      @(posedge pclk); #1;
      if (port == 0 && j == 0) begin
        chk("idle_gap_busy", 64'(busy), 64'd0);
        @(posedge pclk); #1;
        chk("next_arb_busy", 64'(busy), 64'd1);
      end
    end
  endtask

  int lat, n_ctrl, n_rd, bad_gap, last_ctrl_cyc, rd_idx, last_ctrl_idx;

  initial begin
    // ---- reset state ----
    #12;
    chk("rst_psel", 64'(apb.psel_o), 0);
    chk("rst_penable", 64'(apb.penable_o), 0);
    chk("rst_pwrite", 64'(apb.pwrite_o), 0);
    chk("rst_paddr", 64'(apb.paddr_o), 0);
    chk("rst_pwdata", 64'(apb.pwdata_o), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'({done0, done1}), 0);
    chk("rst_err", 64'({err0, err1}), 0);
    chk("rst_rdata", 64'({rdata0, rdata1}), 0);
    @(posedge pclk); #1;
    rst = 1'b0;
    @(posedge pclk); #1;

    // ---- single job, zero wait, busy clear on first poll ----
    clear_logs();
    rd_val = 32'hCDEF_9876; busy_set = 0; ctrl_base = ctrl_reads; waits = 0;
    run_job(0, 8'h03, 32'h0000_0100, 32'd4, 32'hABCD_1234, lat);
    chk("t1_latency", 64'(lat), 64'd16);
    chk("t1_rdata0", 64'(rdata0), 64'hCDEF_9876);
    chk("t1_err0", 64'(err0), 64'd0);
    check_seq(8'h03, 32'h0000_0100, 32'd4, 32'hABCD_1234);
    @(posedge pclk); #1;
    chk("t1_done_one_cycle", 64'(done0), 64'd0);

    // ---- round-robin from reset ----
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge pclk); #1;
    order_q.delete();
    fork
      drive_port(0, 2);
      drive_port(1, 2);
    join
    chk("rr_count", 64'(order_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < order_q.size(); i++)
      chk($sformatf("rr_order_%0d", i), 64'(order_q[i]), 64'(i % 2));
    repeat (3) @(posedge pclk);
    #1;

    // ---- three wait states on every access ----
    clear_logs();
    waits = 3; rd_val = 32'h5555_AAAA; busy_set = 0; ctrl_base = ctrl_reads;
    begin
      int unst0, bad_len;
      unst0 = unstable;
      run_job(1, 8'h0B, 32'h0000_2000, 32'd8, 32'h1357_9BDF, lat);
      chk("ws_latency", 64'(lat), 64'(16 + 7 * 3));
      chk("ws_stable", 64'(unstable - unst0), 64'd0);
      bad_len = 0;
      foreach (len_q[i]) if (len_q[i] != 4) bad_len++;
      chk("ws_access_len", 64'(bad_len), 64'd0);
      chk("ws_access_cnt", 64'(len_q.size()), 64'd7);
      chk("ws_rdata1", 64'(rdata1), 64'h5555_AAAA);
    end
    waits = 0;
    @(posedge pclk); #1;

    // ---- busy for 5 polls ----
    clear_logs();
    rd_val = 32'h0F0F_1234; busy_set = 5; ctrl_base = ctrl_reads;
    run_job(0, 8'h02, 32'h0000_0040, 32'd16, 32'h0, lat);
    n_ctrl = 0; n_rd = 0; bad_gap = 0; last_ctrl_cyc = -1; rd_idx = -1; last_ctrl_idx = -1;
    foreach (log_q[i]) begin
      if (!log_q[i].w && log_q[i].a == 4'd5) begin
        if (n_ctrl > 0 && int'(log_q[i].cyc) - last_ctrl_cyc != 4) bad_gap++;
        last_ctrl_cyc = int'(log_q[i].cyc);
        last_ctrl_idx = i;
        n_ctrl++;
      end
      if (!log_q[i].w && log_q[i].a == 4'd4) begin n_rd++; rd_idx = i; end
    end
    chk("poll_ctrl_reads", 64'(n_ctrl), 64'd6);
    chk("poll_spacing", 64'(bad_gap), 64'd0);
    chk("poll_rdata_reads", 64'(n_rd), 64'd1);
    chk("poll_rdata_after", 64'(rd_idx > last_ctrl_idx), 64'd1);
    chk("poll_latency", 64'(lat), 64'd36);
    chk("poll_rdata0", 64'(rdata0), 64'h0F0F_1234);
    chk("poll_err0", 64'(err0), 64'd0);
    @(posedge pclk); #1;

`ifdef SPI_SCHED_TIMEOUT_EN
    // ---- stuck busy with timeout ----
    clear_logs();
    busy_set = 100000; ctrl_base = ctrl_reads;
    run_job(1, 8'h05, 32'h0, 32'd1, 32'h0, lat);
    n_ctrl = 0; n_rd = 0;
    foreach (log_q[i]) begin
      if (!log_q[i].w && log_q[i].a == 4'd5) n_ctrl++;
      if (!log_q[i].w && log_q[i].a == 4'd4) n_rd++;
    end
    chk("tmo_ctrl_reads", 64'(n_ctrl), 64'd8);
    chk("tmo_rdata_reads", 64'(n_rd), 64'd0);
    chk("tmo_err1", 64'(err1), 64'd1);
    chk("tmo_rdata1", 64'(rdata1), 64'hDEAD_BEEF);
    busy_set = 0;
    @(posedge pclk); #1;
`endif

    // ---- reset during W_LEN ----
    begin
      int t;
      t = 0;
      ctrl_base = ctrl_reads;
      cmd0 = 8'h9F; addr0 = 32'h1; len0 = 32'h2; wdata0 = 32'h3; req0 = 1'b1;
      do begin
        @(posedge pclk); #1;
        t++;
      end while (!(apb.psel_o && apb.paddr_o == 4'd2) && t < 200);
      chk("mid_reached_wlen", 64'(apb.psel_o && apb.paddr_o == 4'd2), 64'd1);
      #2; rst = 1'b1; #1;
      chk("mid_psel", 64'(apb.psel_o), 64'd0);
      chk("mid_penable", 64'(apb.penable_o), 64'd0);
      chk("mid_busy", 64'(busy), 64'd0);
      chk("mid_rdata0", 64'(rdata0), 64'd0);
      chk("mid_paddr", 64'(apb.paddr_o), 64'd0);
      req0 = 1'b0;
      @(posedge pclk); #1;
      rst = 1'b0;
      @(posedge pclk); #1;
    end
    clear_logs();
    rd_val = 32'h1111_2222; busy_set = 0; ctrl_base = ctrl_reads;
    run_job(1, 8'h3B, 32'h00AB_CDEF, 32'd12, 32'hFEED_F00D, lat);
    chk("post_latency", 64'(lat), 64'd16);
    chk("post_rdata1", 64'(rdata1), 64'h1111_2222);
    check_seq(8'h3B, 32'h00AB_CDEF, 32'd12, 32'hFEED_F00D);

    repeat (2) @(posedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
